wb_hilo_stage: RTL and testbench

//  Parametrised writeback stage: owns the M->W pipeline register and the architectural HI/LO registers.

---
 rtl/wb_hilo_stage.sv | 166 ++++++++++++++++
 tb/tb_wb_hilo_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_hilo_stage.sv
// Writeback stage: M->W pipeline register, architectural HI/LO, GPR write port and HI/LO forwarding.
// Optional trace port and retire counter are enabled by defining WB_TRACE_EN.
module wb_hilo_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = $clog2(NUM_SRC + 2)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_W-1:0]     in_rd,
    input  logic                      in_wen,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [NUM_SRC*DATA_W-1:0] in_src,
    input  logic                      in_hi_we,
    input  logic                      in_lo_we,
    input  logic [DATA_W-1:0]         in_hi_data,
    input  logic [DATA_W-1:0]         in_lo_data,
`ifdef WB_TRACE_EN
    input  logic [31:0]               in_pc,
    output logic [31:0]               debug_wb_pc,
    output logic [3:0]                debug_wb_rf_wen,
    output logic [4:0]                debug_wb_rf_wnum,
    output logic [DATA_W-1:0]         debug_wb_rf_wdata,
    output logic [31:0]               retired_cnt,
`endif
    input  logic                      stall,
    input  logic                      flush,
    output logic                      rf_we,
    output logic [REG_ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [DATA_W-1:0]         hi,
    output logic [DATA_W-1:0]         lo,
    output logic [DATA_W-1:0]         hi_fwd,
    output logic [DATA_W-1:0]         lo_fwd
);

    logic                      w_valid_q,   w_valid_d;
    logic [REG_ADDR_W-1:0]     w_rd_q,      w_rd_d;
    logic                      w_wen_q,     w_wen_d;
    logic [SEL_W-1:0]          w_sel_q,     w_sel_d;
    logic [NUM_SRC*DATA_W-1:0] w_src_q,     w_src_d;
    logic                      w_hi_we_q,   w_hi_we_d;
    logic                      w_lo_we_q,   w_lo_we_d;
    logic [DATA_W-1:0]         w_hi_data_q, w_hi_data_d;
    logic [DATA_W-1:0]         w_lo_data_q, w_lo_data_d;
    logic [DATA_W-1:0]         hi_q,        hi_d;
    logic [DATA_W-1:0]         lo_q,        lo_d;
`ifdef WB_TRACE_EN
    logic [31:0]               w_pc_q,        w_pc_d;
    logic [31:0]               retired_cnt_q, retired_cnt_d;
`endif

    logic              capture;
    logic              commit;
    logic [DATA_W-1:0] result;

    assign in_ready = !w_valid_q || !stall;
    assign capture  = in_valid && in_ready && !flush;
    assign commit   = w_valid_q && !stall;

    // HI/LO selection reads the registers, so an entry never sees its own HI/LO write.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        result = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_sel_q == SEL_W'(i)) result = w_src_q[i*DATA_W +: DATA_W];
        end
        if (w_sel_q == SEL_W'(NUM_SRC))     result = hi_q;
        if (w_sel_q == SEL_W'(NUM_SRC + 1)) result = lo_q;
    end

    always_comb begin
        w_rd_d      = w_rd_q;
        w_wen_d     = w_wen_q;
        w_sel_d     = w_sel_q;
        w_src_d     = w_src_q;
        w_hi_we_d   = w_hi_we_q;
        w_lo_we_d   = w_lo_we_q;
        w_hi_data_d = w_hi_data_q;
        w_lo_data_d = w_lo_data_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
`ifdef WB_TRACE_EN
        w_pc_d        = w_pc_q;
        retired_cnt_d = commit ? retired_cnt_q + 32'd1 : retired_cnt_q;
`endif
        // Flush drops a stalled entry; a committing entry has already retired this edge.
        if (capture)              w_valid_d = 1'b1;
        else if (commit || flush) w_valid_d = 1'b0;
        else                      w_valid_d = w_valid_q;

        if (capture) begin
            w_rd_d      = in_rd;
            w_wen_d     = in_wen;
            w_sel_d     = in_sel;
            w_src_d     = in_src;
            w_hi_we_d   = in_hi_we;
            w_lo_we_d   = in_lo_we;
            w_hi_data_d = in_hi_data;
            w_lo_data_d = in_lo_data;
`ifdef WB_TRACE_EN
            w_pc_d      = in_pc;
`endif
        end

        if (commit && w_hi_we_q) hi_d = w_hi_data_q;
        if (commit && w_lo_we_q) lo_d = w_lo_data_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_valid_q     <= 1'b0;
            w_rd_q        <= '0;
            w_wen_q       <= 1'b0;
            w_sel_q       <= '0;
            w_src_q       <= '0;
            w_hi_we_q     <= 1'b0;
            w_lo_we_q     <= 1'b0;
            w_hi_data_q   <= '0;
            w_lo_data_q   <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
`ifdef WB_TRACE_EN
            w_pc_q        <= '0;
            retired_cnt_q <= '0;
`endif
        end else begin
            // NOTE: state updates are non-blocking so every flop samples pre-edge values.
            w_valid_q     <= w_valid_d;
            w_rd_q        <= w_rd_d;
            w_wen_q       <= w_wen_d;
            w_sel_q       <= w_sel_d;
            w_src_q       <= w_src_d;
            w_hi_we_q     <= w_hi_we_d;
            w_lo_we_q     <= w_lo_we_d;
            w_hi_data_q   <= w_hi_data_d;
            w_lo_data_q   <= w_lo_data_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
`ifdef WB_TRACE_EN
            w_pc_q        <= w_pc_d;
            retired_cnt_q <= retired_cnt_d;
`endif
        end
    end

    assign rf_we    = commit && w_wen_q && (w_rd_q != '0);
    assign rf_waddr = w_rd_q;
    assign rf_wdata = result;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign hi_fwd   = (commit && w_hi_we_q) ? w_hi_data_q : hi_q;
    assign lo_fwd   = (commit && w_lo_we_q) ? w_lo_data_q : lo_q;

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = w_pc_q;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = 5'(w_rd_q);
    assign debug_wb_rf_wdata = result;
    assign retired_cnt       = retired_cnt_q;
`endif

endmodule

// File: tb/tb_wb_hilo_stage.sv
// Self-checking bench for wb_hilo_stage (default build): scoreboard of GPR writes plus directed
// checks of reset, stall, flush and HI/LO forwarding.
module tb_wb_hilo_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   in_rd;
    logic         in_wen;
    logic [2:0]   in_sel;
    logic [127:0] in_src;
    logic         in_hi_we, in_lo_we;
    logic [31:0]  in_hi_data, in_lo_data;
    logic         stall, flush;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata, hi, lo, hi_fwd, lo_fwd;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    wb_hilo_stage dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_wen(in_wen), .in_sel(in_sel), .in_src(in_src),
        .in_hi_we(in_hi_we), .in_lo_we(in_lo_we),
        .in_hi_data(in_hi_data), .in_lo_data(in_lo_data),
        .stall(stall), .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hi(hi), .lo(lo), .hi_fwd(hi_fwd), .lo_fwd(lo_fwd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction for one edge; with keep=1 the model predicts its GPR write and HI/LO effect.
    task automatic issue(input bit keep, input logic [4:0] rd, input bit wen, input int sel,
                         input logic [127:0] src, input bit hwe, input bit lwe,
                         input logic [31:0] hd, input logic [31:0] ld);
        logic [31:0] r;
        in_valid   = 1'b1;
        in_rd      = rd;
        in_wen     = wen;
        in_sel     = 3'(sel);
        in_src     = src;
        in_hi_we   = hwe;
        in_lo_we   = lwe;
        in_hi_data = hd;
        in_lo_data = ld;
        if (keep) begin
            if (sel < 4)       r = src[sel*32 +: 32];
            else if (sel == 4) r = model_hi;
            else if (sel == 5) r = model_lo;
            else               r = '0;
            if (wen && rd != 5'd0) sb.push_back('{addr: rd, data: r});
            if (hwe) model_hi = hd;
            if (lwe) model_lo = ld;
        end
        tick();
    endtask

    always @(negedge clk) begin
        if (resetn && rf_we) begin
            if (sb.size() == 0) begin
                check("rf_spurious", 64'(rf_we), 64'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("rf_waddr", 64'(rf_waddr), 64'(e.addr));
                check("rf_wdata", 64'(rf_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] old_hi;
        resetn = 1'b0; in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_sel = '0; in_src = '0;
        in_hi_we = 1'b0; in_lo_we = 1'b0; in_hi_data = '0; in_lo_data = '0;
        stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_we",    64'(rf_we),    64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_hi",    64'(hi),       64'd0);
        check("rst_lo",    64'(lo),       64'd0);

        // Reset asserted while an entry is committing.
        issue(1, 5'd0, 1'b0, 0, 128'h0, 1'b1, 1'b0, 32'h1111, 32'h0);
        issue(0, 5'd4, 1'b1, 0, 128'h99, 1'b0, 1'b1, 32'h0, 32'h2222);
        in_valid = 1'b0;
        check("pre_rst_hi", 64'(hi), 64'h1111);
        #1 check("pre_rst_we", 64'(rf_we), 64'd1);
        #1 resetn = 1'b0;
        #1;
        check("midrst_we",    64'(rf_we),    64'd0);
        check("midrst_hi",    64'(hi),       64'd0);
        check("midrst_lo",    64'(lo),       64'd0);
        check("midrst_wdata", 64'(rf_wdata), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        tick();
        resetn = 1'b1;
        model_hi = '0;
        model_lo = '0;

        // ALU write, then a write to r0 that must be suppressed.
        issue(1, 5'd5, 1'b1, 0, 128'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("alu_we",    64'(rf_we),    64'd1);
        check("alu_waddr", 64'(rf_waddr), 64'd5);
        check("alu_wdata", 64'(rf_wdata), 64'h1234);
        issue(1, 5'd0, 1'b1, 0, 128'h5678, 1'b0, 1'b0, 32'h0, 32'h0);
        in_valid = 1'b0;
        #1 check("rd0_we", 64'(rf_we), 64'd0);

        // mthi then mfhi back-to-back.
        issue(1, 5'd0, 1'b0, 0, 128'h0, 1'b1, 1'b0, 32'hDEAD, 32'h0);
        #1;
        check("mthi_fwd",    64'(hi_fwd), 64'hDEAD);
        check("mthi_hi_old", 64'(hi),     64'h0);
        issue(1, 5'd7, 1'b1, 4, 128'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        in_valid = 1'b0;
        #1;
        check("mfhi_wdata", 64'(rf_wdata), 64'hDEAD);
        tick();

        // Stalled entry with HI write: held three cycles, commits once on release.
        old_hi = model_hi;
        issue(1, 5'd3, 1'b1, 0, 128'hAA, 1'b1, 1'b0, 32'h55, 32'h0);
        in_valid = 1'b0;
        stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 64'(in_ready), 64'd0);
            check("stall_we",    64'(rf_we),    64'd0);
            check("stall_hi",    64'(hi),       64'(old_hi));
            check("stall_fwd",   64'(hi_fwd),   64'(old_hi));
            tick();
        end
        stall = 1'b0;
        #1;
        check("release_we",  64'(rf_we),  64'd1);
        check("release_fwd", 64'(hi_fwd), 64'h55);
        tick();
        check("release_hi",    64'(hi),    64'h55);
        check("release_once",  64'(rf_we), 64'd0);

        // Flush of a stalled entry: dropped without commit.
        issue(0, 5'd9, 1'b1, 0, 128'h9, 1'b1, 1'b0, 32'hBAD, 32'h0);
        in_valid = 1'b0;
        stall    = 1'b1;
        tick();
        flush = 1'b1;
        #1 check("flush_st_we", 64'(rf_we), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_st_drop", 64'(in_ready), 64'd1);
        check("flush_st_hi",   64'(hi),       64'(model_hi));
        stall = 1'b0;
        tick();
        check("flush_st_hi2", 64'(hi),    64'(model_hi));
        check("flush_st_we2", 64'(rf_we), 64'd0);

        // Flush with an unstalled entry: it commits, the incoming one is dropped.
        issue(1, 5'd10, 1'b1, 1, 128'h77_0000_0000, 1'b0, 1'b0, 32'h0, 32'h0);
        in_valid = 1'b1;
        in_rd    = 5'd11;
        in_wen   = 1'b1;
        in_sel   = 3'd0;
        in_src   = 128'h3333;
        flush    = 1'b1;
        #1 check("flush_c_we", 64'(rf_we), 64'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        stall    = 1'b1;
        #1;
        check("flush_c_drop", 64'(in_ready), 64'd1);
        check("flush_c_we2",  64'(rf_we),    64'd0);
        stall = 1'b0;

        // Mult-style HI+LO update, mflo, and an out-of-range select.
        issue(1, 5'd0, 1'b0, 0, 128'h0, 1'b1, 1'b1, 32'h1, 32'hFFFF_FFFF);
        #1;
        check("mult_hi_fwd", 64'(hi_fwd), 64'h1);
        check("mult_lo_fwd", 64'(lo_fwd), 64'hFFFF_FFFF);
        issue(1, 5'd12, 1'b1, 5, 128'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("mult_hi", 64'(hi), 64'h1);
        check("mult_lo", 64'(lo), 64'hFFFF_FFFF);
        issue(1, 5'd13, 1'b1, 6, {4{32'hCAFE_F00D}}, 1'b0, 1'b0, 32'h0, 32'h0);
        in_valid = 1'b0;
        #1 check("badsel_wdata", 64'(rf_wdata), 64'd0);
        tick();

        // Random back-to-back traffic through the scoreboard.
        for (int i = 0; i < 40; i++) begin
            issue(1, 5'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 7)),
                  {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom),
                  $urandom, $urandom);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("end_hi",   64'(hi),       64'(model_hi));
        check("end_lo",   64'(lo),       64'(model_lo));
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
